// File: rtl/key_debounce.sv
// Per-key pad conditioning: 2-flop synchronizer, counter debounce, press/release pulses
// and an optional hold-to-repeat generator. key_state is active-high regardless of pad polarity.
module key_debounce #(
   parameter int N_KEYS          = 4,
   parameter int KEY_ACTIVE_LOW  = 1,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 0,
   parameter int REPEAT_RATE     = 5000000
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic [N_KEYS-1:0] key_raw,
   output logic [N_KEYS-1:0] key_state,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_repeat
);

   localparam int DW   = $clog2(DEBOUNCE_CYCLES);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = $clog2(RMAX + 1);

   localparam logic [DW-1:0] DC_MAX = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] RD_MAX = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
   localparam logic [RW-1:0] RR_MAX = RW'(REPEAT_RATE - 1);

   localparam logic [1:0] ST_REL  = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd1;
   localparam logic [1:0] ST_REPT = 2'd2;

   // Pad level that means "not pressed"; the synchronizer resets to it so reset never looks like a press.
   localparam logic [N_KEYS-1:0] RELEASED_PAD = {N_KEYS{(KEY_ACTIVE_LOW != 0)}};

   logic [N_KEYS-1:0] r_sync1;
   logic [N_KEYS-1:0] r_sync2;
   logic [N_KEYS-1:0] w_pressed;

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_sync1 <= RELEASED_PAD;
         r_sync2 <= RELEASED_PAD;
      end else begin
         r_sync1 <= key_raw;
         r_sync2 <= r_sync1;
      end
   end

   assign w_pressed = r_sync2 ^ RELEASED_PAD;

   for (genvar g = 0; g < N_KEYS; g++) begin : g_key
      logic [DW-1:0] r_dcnt;
      logic [RW-1:0] r_rcnt;
      logic [1:0]    r_rstate;
      logic          r_keyState;
      logic          r_press;
      logic          r_release;
      logic          r_repeat;
      logic          w_change;
      logic          w_accept;
      logic          w_pressAcc;
      logic          w_relAcc;

      assign w_change   = (w_pressed[g] != r_keyState);
      assign w_accept   = w_change && (r_dcnt == DC_MAX);
      assign w_pressAcc = w_accept &&  w_pressed[g];
      assign w_relAcc   = w_accept && !w_pressed[g];

      always_ff @(posedge clk_clk) begin
         if (!reset_reset_n) begin
            r_dcnt     <= '0;
            r_keyState <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
         end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (!w_change) begin
               r_dcnt <= '0;
            end else if (r_dcnt == DC_MAX) begin
               r_keyState <= w_pressed[g];
               r_dcnt     <= '0;
               r_press    <= w_pressed[g];
               r_release  <= !w_pressed[g];
            end else begin
               r_dcnt <= r_dcnt + 1'b1;
            end
         end
      end

      // Driven from the accept event rather than the registered pulse so the first repeat
      // lands exactly REPEAT_DELAY cycles after key_press; release wins over a coincident repeat.
      always_ff @(posedge clk_clk) begin
         if (!reset_reset_n) begin
            r_rstate <= ST_REL;
            r_rcnt   <= '0;
            r_repeat <= 1'b0;
         end else begin
            r_repeat <= 1'b0;
            case (r_rstate)
               ST_REL: begin
                  if (w_pressAcc) begin
                     r_rstate <= ST_HOLD;
                     r_rcnt   <= '0;
                  end
               end
               ST_HOLD: begin
                  if (w_relAcc) begin
                     r_rstate <= ST_REL;
                     r_rcnt   <= '0;
                  end else if (REPEAT_DELAY == 0) begin
                     r_rcnt <= '0;
                  end else if (r_rcnt == RD_MAX) begin
                     r_repeat <= 1'b1;
                     r_rstate <= ST_REPT;
                     r_rcnt   <= '0;
                  end else begin
                     r_rcnt <= r_rcnt + 1'b1;
                  end
               end
               ST_REPT: begin
                  if (w_relAcc) begin
                     r_rstate <= ST_REL;
                     r_rcnt   <= '0;
                  end else if (r_rcnt == RR_MAX) begin
                     r_repeat <= 1'b1;
                     r_rcnt   <= '0;
                  end else begin
                     r_rcnt <= r_rcnt + 1'b1;
                  end
               end
               default: begin
                  r_rstate <= ST_REL;
                  r_rcnt   <= '0;
               end
            endcase
         end
      end

      assign key_state[g]   = r_keyState;
      assign key_press[g]   = r_press;
      assign key_release[g] = r_release;
      assign key_repeat[g]  = r_repeat;
   end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_RATE=5.
// Step counts are edges after an input change: step 1 is the edge that first samples it.
module tb_key_debounce;

   logic       clk_clk;
   logic       reset_reset_n;
   logic [3:0] key_raw;
   logic [3:0] key_state;
   logic [3:0] key_press;
   logic [3:0] key_release;
   logic [3:0] key_repeat;

   int compared   = 0;
   int mismatched = 0;

   key_debounce #(
      .N_KEYS          (4),
      .KEY_ACTIVE_LOW  (1),
      .DEBOUNCE_CYCLES (8),
      .REPEAT_DELAY    (20),
      .REPEAT_RATE     (5)
   ) dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .key_raw       (key_raw),
      .key_state     (key_state),
      .key_press     (key_press),
      .key_release   (key_release),
      .key_repeat    (key_repeat)
   );

   initial clk_clk = 1'b0;
   always #5 clk_clk = ~clk_clk;

   task automatic step();
      @(posedge clk_clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [3:0] eSt, input logic [3:0] ePr,
                              input logic [3:0] eRl, input logic [3:0] eRp);
      logic [15:0] obs;
      logic [15:0] exp;
      obs = {key_state, key_press, key_release, key_repeat};
      exp = {eSt, ePr, eRl, eRp};
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed st/pr/rl/rp=%h required %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_reset_n = 1'b0;
      key_raw       = 4'hF;

      for (int i = 1; i <= 3; i++) begin
         step();
         checkOutput($sformatf("reset i=%0d", i), 4'h0, 4'h0, 4'h0, 4'h0);
      end
      reset_reset_n = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step();
         checkOutput($sformatf("idle i=%0d", i), 4'h0, 4'h0, 4'h0, 4'h0);
      end

      // Clean press and clean release of key 0
      key_raw[0] = 1'b0;
      for (int j = 1; j <= 12; j++) begin
         step();
         checkOutput($sformatf("press0 j=%0d", j), (j >= 10) ? 4'h1 : 4'h0,
                     (j == 10) ? 4'h1 : 4'h0, 4'h0, 4'h0);
      end
      key_raw[0] = 1'b1;
      for (int j = 1; j <= 12; j++) begin
         step();
         checkOutput($sformatf("rel0 j=%0d", j), (j < 10) ? 4'h1 : 4'h0,
                     4'h0, (j == 10) ? 4'h1 : 4'h0, 4'h0);
      end

      // Key 1 bounces with 3-cycle segments, then settles pressed
      for (int s = 0; s < 10; s++) begin
         key_raw[1] = (s % 2 == 0) ? 1'b0 : 1'b1;
         for (int c = 1; c <= 3; c++) begin
            step();
            checkOutput($sformatf("bounce s=%0d c=%0d", s, c), 4'h0, 4'h0, 4'h0, 4'h0);
         end
      end
      key_raw[1] = 1'b0;
      for (int j = 1; j <= 12; j++) begin
         step();
         checkOutput($sformatf("settle1 j=%0d", j), (j >= 10) ? 4'h2 : 4'h0,
                     (j == 10) ? 4'h2 : 4'h0, 4'h0, 4'h0);
      end
      key_raw[1] = 1'b1;
      for (int j = 1; j <= 12; j++) begin
         step();
         checkOutput($sformatf("rel1 j=%0d", j), (j < 10) ? 4'h2 : 4'h0,
                     4'h0, (j == 10) ? 4'h2 : 4'h0, 4'h0);
      end

      // Key 2 low for one cycle short of acceptance
      key_raw[2] = 1'b0;
      for (int j = 1; j <= 7; j++) begin
         step();
         checkOutput($sformatf("glitch lo j=%0d", j), 4'h0, 4'h0, 4'h0, 4'h0);
      end
      key_raw[2] = 1'b1;
      for (int j = 1; j <= 12; j++) begin
         step();
         checkOutput($sformatf("glitch hi j=%0d", j), 4'h0, 4'h0, 4'h0, 4'h0);
      end

      // Key 3 hold/repeat; release lands on the +65 repeat slot and must win
      key_raw[3] = 1'b0;
      for (int j = 1; j <= 10; j++) begin
         step();
         checkOutput($sformatf("press3 j=%0d", j), (j == 10) ? 4'h8 : 4'h0,
                     (j == 10) ? 4'h8 : 4'h0, 4'h0, 4'h0);
      end
      for (int t = 1; t <= 75; t++) begin
         step();
         checkOutput($sformatf("hold3 t=%0d", t), (t < 65) ? 4'h8 : 4'h0, 4'h0,
                     (t == 65) ? 4'h8 : 4'h0,
                     (t >= 20 && t <= 60 && (t % 5 == 0)) ? 4'h8 : 4'h0);
         if (t == 55) key_raw[3] = 1'b1;
      end

      // All keys together; keys 1-3 released, key 0 keeps repeating
      key_raw = 4'h0;
      for (int j = 1; j <= 42; j++) begin
         step();
         checkOutput($sformatf("simul j=%0d", j),
                     (j < 10) ? 4'h0 : ((j < 22) ? 4'hF : 4'h1),
                     (j == 10) ? 4'hF : 4'h0,
                     (j == 22) ? 4'hE : 4'h0,
                     (j == 30 || j == 35 || j == 40) ? 4'h1 : 4'h0);
         if (j == 12) key_raw = 4'hE;
      end

      // Reset while key 0 is held and repeating
      reset_reset_n = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step();
         checkOutput($sformatf("midreset i=%0d", i), 4'h0, 4'h0, 4'h0, 4'h0);
      end
      reset_reset_n = 1'b1;
      for (int k = 1; k <= 35; k++) begin
         step();
         checkOutput($sformatf("postreset k=%0d", k), (k >= 10) ? 4'h1 : 4'h0,
                     (k == 10) ? 4'h1 : 4'h0, 4'h0,
                     (k == 30 || k == 35) ? 4'h1 : 4'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
